ccl_loop_stack: RTL and testbench

CCL_LOOP_STACK -- requirements
Module: ccl_loop_stack

---
 rtl/ccl_loop_stack.sv | 178 +++++++++++++++++
 tb/tb_ccl_loop_stack.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ccl_loop_stack.sv
// Hardware loop stack. Tracks nested counted loops keyed by loop-end address.
// Each LOOP command either branches back (taken_o, out_target_o) or exits.
// One-cycle response latency, one command per cycle, no stall.
// Ports:
//   clock_i, reset_i        : clock, synchronous active-high reset
//   cmd_valid_i, command_i  : command strobe and opcode (NOP/BREAK/LOOP/FLUSH)
//   address_i, counter_i,
//   in_target_i             : LOOP operands (loop-end address, count, target)
//   resp_valid_o, taken_o,
//   out_target_o            : registered response and branch target
//   error_o, err_code_o     : error strobe and code
//   full_o, empty_o,
//   occupancy_o             : stack level after all accepted commands
module ccl_loop_stack #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  input  logic [2:0]        command_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [CNT_W-1:0]  counter_i,
  input  logic [ADDR_W-1:0] in_target_i,
  output logic              resp_valid_o,
  output logic              taken_o,
  output logic [ADDR_W-1:0] out_target_o,
  output logic              error_o,
  output logic [2:0]        err_code_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [OCC_W-1:0]  occupancy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_BREAK = 3'b001;
  localparam logic [2:0] CMD_LOOP  = 3'b010;
  localparam logic [2:0] CMD_FLUSH = 3'b011;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL = 3'd1;
  localparam logic [2:0] ERR_ZERO    = 3'd2;
  localparam logic [2:0] ERR_OVER    = 3'd3;
  localparam logic [2:0] ERR_UNDER   = 3'd4;

  // Entry storage; contents are don't-care until pushed, so not reset.
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [CNT_W-1:0]  rem_mem  [DEPTH];

  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              resp_valid_q;
  logic              taken_q, taken_d;
  logic              error_q, error_d;
  logic [2:0]        err_code_q, err_code_d;
  logic [ADDR_W-1:0] target_q, target_d;

  logic              push, pop, dec, hit;
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] top_addr;
  logic [CNT_W-1:0]  top_rem;

  // Top-of-stack view; index is only meaningful when not empty.
  assign top_idx  = PTR_W'(occ_q - OCC_W'(1));
  assign top_addr = addr_mem[top_idx];
  assign top_rem  = rem_mem[top_idx];
  assign hit      = !empty_q && (address_i == top_addr);

  // Command decode and next-state computation.
  always_comb begin
    occ_d      = occ_q;
    push       = 1'b0;
    pop        = 1'b0;
    dec        = 1'b0;
    taken_d    = 1'b0;
    error_d    = 1'b0;
    err_code_d = ERR_NONE;
    target_d   = target_q;
    if (cmd_valid_i && !reset_i) begin
      case (command_i)
        CMD_NOP: ;
        CMD_BREAK: begin
          if (empty_q) begin
            error_d    = 1'b1;
            err_code_d = ERR_UNDER;
          end else begin
            pop = 1'b1;
          end
        end
        CMD_LOOP: begin
          if (hit) begin
            // Branch back while iterations are owed, otherwise exit the loop.
            if (top_rem != '0) begin
              dec      = 1'b1;
              taken_d  = 1'b1;
              target_d = in_target_i;
            end else begin
              pop = 1'b1;
            end
          end else if (counter_i == '0) begin
            error_d    = 1'b1;
            err_code_d = ERR_ZERO;
          end else if (counter_i == CNT_W'(1)) begin
            // Single-pass loop: fall through without tracking it.
          end else if (full_q) begin
            error_d    = 1'b1;
            err_code_d = ERR_OVER;
          end else begin
            // This pass is the first branch-back, so N-2 remain after it.
            push     = 1'b1;
            taken_d  = 1'b1;
            target_d = in_target_i;
          end
        end
        CMD_FLUSH: occ_d = '0;
        default: begin
          error_d    = 1'b1;
          err_code_d = ERR_ILLEGAL;
        end
      endcase
    end
    if (push) begin
      occ_d = OCC_W'(occ_q + OCC_W'(1));
    end else if (pop) begin
      occ_d = OCC_W'(occ_q - OCC_W'(1));
    end
    full_d  = (occ_d == OCC_W'(DEPTH));
    empty_d = (occ_d == '0);
  end

  // Control state and registered response.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      occ_q        <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      taken_q      <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      target_q     <= '0;
    end else begin
      occ_q        <= occ_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      resp_valid_q <= cmd_valid_i;
      taken_q      <= taken_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      target_q     <= target_d;
    end
  end

  // Entry writes: push fills the slot above the top, dec updates top.rem.
  always_ff @(posedge clock_i) begin
    if (push) begin
      addr_mem[occ_q[PTR_W-1:0]] <= address_i;
      rem_mem[occ_q[PTR_W-1:0]]  <= CNT_W'(counter_i - CNT_W'(2));
    end else if (dec) begin
      rem_mem[top_idx] <= CNT_W'(top_rem - CNT_W'(1));
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign taken_o      = taken_q;
  assign out_target_o = target_q;
  assign error_o      = error_q;
  assign err_code_o   = err_code_q;
  assign full_o       = full_q;
  assign empty_o      = empty_q;
  assign occupancy_o  = occ_q;

endmodule

// File: tb/tb_ccl_loop_stack.sv
// Bench for ccl_loop_stack (DEPTH=4): directed scenarios then random
// commands, each response compared with a queue-based reference model.
module tb_ccl_loop_stack;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic [2:0]        command;
  logic [ADDR_W-1:0] address;
  logic [CNT_W-1:0]  counter;
  logic [ADDR_W-1:0] in_target;
  logic              resp_valid;
  logic              taken;
  logic [ADDR_W-1:0] out_target;
  logic              error;
  logic [2:0]        err_code;
  logic              full;
  logic              empty;
  logic [OCC_W-1:0]  occupancy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: a stack of {addr, remaining branch-backs}.
  logic [ADDR_W-1:0] m_addr[$];
  logic [CNT_W-1:0]  m_rem[$];
  logic [ADDR_W-1:0] exp_tgt;

  always #5 clock = ~clock;

  ccl_loop_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .cmd_valid_i  (cmd_valid),
    .command_i    (command),
    .address_i    (address),
    .counter_i    (counter),
    .in_target_i  (in_target),
    .resp_valid_o (resp_valid),
    .taken_o      (taken),
    .out_target_o (out_target),
    .error_o      (error),
    .err_code_o   (err_code),
    .full_o       (full),
    .empty_o      (empty),
    .occupancy_o  (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic rv, input logic tk,
                            input logic er, input logic [2:0] code);
    int n;
    n = m_addr.size();
    chk({tag, ".resp_valid"}, 64'(resp_valid), 64'(rv));
    chk({tag, ".taken"},      64'(taken),      64'(tk));
    chk({tag, ".error"},      64'(error),      64'(er));
    chk({tag, ".err_code"},   64'(err_code),   64'(code));
    chk({tag, ".out_target"}, 64'(out_target), 64'(exp_tgt));
    chk({tag, ".occupancy"},  64'(occupancy),  64'(n));
    chk({tag, ".full"},       64'(full),       64'(n == DEPTH));
    chk({tag, ".empty"},      64'(empty),      64'(n == 0));
  endtask

  // Issue one cycle of input, advance the model, then compare the response.
  task automatic step(input string tag, input logic v, input logic [2:0] cmd,
                      input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] c,
                      input logic [ADDR_W-1:0] t);
    logic       e_tk;
    logic       e_er;
    logic [2:0] e_code;
    int         n;
    e_tk   = 1'b0;
    e_er   = 1'b0;
    e_code = 3'd0;
    cmd_valid = v;
    command   = cmd;
    address   = a;
    counter   = c;
    in_target = t;
    n = m_addr.size();
    if (v) begin
      if (cmd == 3'd0) begin
      end else if (cmd == 3'd1) begin
        if (n == 0) begin e_er = 1'b1; e_code = 3'd4; end
        else begin void'(m_addr.pop_back()); void'(m_rem.pop_back()); end
      end else if (cmd == 3'd2) begin
        if (n > 0 && m_addr[n-1] == a) begin
          if (m_rem[n-1] > 0) begin
            m_rem[n-1] = m_rem[n-1] - 1;
            e_tk = 1'b1;
            exp_tgt = t;
          end else begin
            void'(m_addr.pop_back()); void'(m_rem.pop_back());
          end
        end else if (c == 0) begin
          e_er = 1'b1; e_code = 3'd2;
        end else if (c == 1) begin
        end else if (n == DEPTH) begin
          e_er = 1'b1; e_code = 3'd3;
        end else begin
          m_addr.push_back(a);
          m_rem.push_back(c - 2);
          e_tk = 1'b1;
          exp_tgt = t;
        end
      end else if (cmd == 3'd3) begin
        m_addr.delete();
        m_rem.delete();
      end else begin
        e_er = 1'b1; e_code = 3'd1;
      end
    end
    @(posedge clock);
    #1;
    expect_all(tag, v, e_tk, e_er, e_code);
  endtask

  task automatic do_reset(input string tag, input logic v);
    reset     = 1'b1;
    cmd_valid = v;
    command   = 3'd2;
    address   = 32'h100;
    counter   = 32'd5;
    in_target = 32'h44;
    @(posedge clock);
    #1;
    m_addr.delete();
    m_rem.delete();
    exp_tgt = '0;
    expect_all(tag, 1'b0, 1'b0, 1'b0, 3'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] addrs [4];
    addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h30; addrs[3] = 32'h40;
    exp_tgt = '0;

    // Reset state.
    do_reset("reset", 1'b0);
    step("idle", 1'b0, 3'd0, '0, '0, '0);
    step("nop", 1'b1, 3'd0, 32'h5, 32'd3, 32'h9);

    // Counted loop: taken 1,1,0.
    step("cnt_a", 1'b1, 3'd2, 32'h100, 32'd3, 32'h80);
    step("cnt_b", 1'b1, 3'd2, 32'h100, 32'd3, 32'h80);
    step("cnt_c", 1'b1, 3'd2, 32'h100, 32'd3, 32'h80);
    chk("cnt.target_held", 64'(out_target), 64'h80);

    // Nesting: taken 1,1,0,0.
    step("nest_a", 1'b1, 3'd2, 32'h200, 32'd2, 32'hA0);
    step("nest_b", 1'b1, 3'd2, 32'h100, 32'd2, 32'hB0);
    step("nest_c", 1'b1, 3'd2, 32'h100, 32'd2, 32'hB0);
    step("nest_d", 1'b1, 3'd2, 32'h200, 32'd2, 32'hA0);

    // Overflow at DEPTH.
    for (int i = 0; i < 5; i++)
      step($sformatf("ovf_%0d", i), 1'b1, 3'd2, 32'h1000 + 32'(i) * 32'h10, 32'd5, 32'h300 + 32'(i));
    chk("ovf.full_const", 64'(full), 64'd1);
    chk("ovf.code_const", 64'(err_code), 64'd3);

    // Deeper-entry match is a miss (also full -> overflow).
    step("deep_miss", 1'b1, 3'd2, 32'h1000, 32'd5, 32'h55);

    // BREAK once, then FLUSH from occupancy 3.
    step("brk", 1'b1, 3'd1, '0, '0, '0);
    step("flush", 1'b1, 3'd3, '0, '0, '0);
    chk("flush.occ_const", 64'(occupancy), 64'd0);
    step("flush_empty", 1'b1, 3'd3, '0, '0, '0);

    // Edge counts and error codes.
    step("cnt0", 1'b1, 3'd2, 32'h400, 32'd0, 32'h1);
    step("cnt1", 1'b1, 3'd2, 32'h400, 32'd1, 32'h2);
    step("brk_empty", 1'b1, 3'd1, '0, '0, '0);
    step("illegal", 1'b1, 3'b101, '0, '0, '0);

    // Reset asserted with a LOOP mid-loop; next LOOP is a miss.
    step("mid_a", 1'b1, 3'd2, 32'h600, 32'd4, 32'h60);
    step("mid_b", 1'b1, 3'd2, 32'h700, 32'd4, 32'h70);
    do_reset("mid_rst", 1'b1);
    step("mid_after", 1'b1, 3'd2, 32'h700, 32'd4, 32'h71);

    // Random traffic over a small address set so hits are frequent.
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      logic [2:0] cmd;
      logic v;
      r = $urandom_range(0, 11);
      v = 1'b1;
      if (r == 0) cmd = 3'd0;
      else if (r == 1) cmd = 3'd1;
      else if (r == 2) cmd = ($urandom_range(0, 2) == 0) ? 3'd3 : 3'd2;
      else if (r == 3) cmd = 3'(4 + $urandom_range(0, 3));
      else if (r == 4) begin cmd = 3'd2; v = 1'b0; end
      else cmd = 3'd2;
      step("rnd", v, cmd, addrs[$urandom_range(0, 3)], 32'($urandom_range(0, 4)),
           32'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
